// File: rtl/ltoh_capture_fifo.sv
// Slow strobe (wclk) synchroniser into rclk, selectable edge detect with start-up arming,
// and a show-ahead capture FIFO with occupancy and sticky overflow on a valid/ready output.
module ltoh_capture_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ADD_WIDTH   = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  wclk,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  pe,
  output logic [ADD_WIDTH:0]    level,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int                 ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(SYNC_STAGES + 1);
  localparam logic [ADD_WIDTH:0] FULL_LVL = (ADD_WIDTH + 1)'(DEPTH);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [ARM_W-1:0]       r_arm_cnt;

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [ADD_WIDTH-1:0]   r_wr_ptr;
  logic [ADD_WIDTH-1:0]   r_rd_ptr;
  logic [ADD_WIDTH:0]     r_level;
  logic                   r_overflow;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_sel;
  logic w_arm_done;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_ovf_evt;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_s & ~r_prev;
  assign w_fall     = ~w_s & r_prev;
  // Arming outlasts the chain fill, so a static wclk level at reset release never looks like an edge.
  assign w_arm_done = (r_arm_cnt == ARM_LAST);

  always_comb begin
    w_sel = w_rise;
    if (EDGE_MODE == 1)      w_sel = w_fall;
    else if (EDGE_MODE == 2) w_sel = w_rise | w_fall;
  end

  assign pe = w_arm_done & w_sel;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], wclk};
      r_prev <= w_s;
      if (!w_arm_done) r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LVL);
  assign w_pop     = ~w_empty & dout_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok = pe & (~w_full | w_pop);
  assign w_ovf_evt = pe & w_full & ~w_pop;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign dout       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign dout_valid = ~w_empty;
  assign level      = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ltoh_capture_fifo.sv
// Bench for ltoh_capture_fifo: three instances (rising, falling, both edges) share stimulus
// and are compared every cycle against a sample-history / queue reference model.
module tb_ltoh_capture_fifo;

  localparam int DW   = 32;
  localparam int SYNC = 2;
  localparam int DEP  = 4;
  localparam int AW   = 2;

  logic          rclk;
  logic          rst;
  logic          wclk;
  logic [DW-1:0] din;
  logic          dout_ready;
  logic          clr_ovf;

  logic [DW-1:0] o_dout  [3];
  logic          o_valid [3];
  logic          o_pe    [3];
  logic [AW:0]   o_level [3];
  logic          o_ovf   [3];

  int checks;
  int errors;

  // clock / reset block
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  ltoh_capture_fifo #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .DEPTH(DEP), .ADD_WIDTH(AW), .EDGE_MODE(0)) u_dut0 (
    .rclk(rclk), .rst(rst), .wclk(wclk), .din(din), .dout(o_dout[0]), .dout_valid(o_valid[0]),
    .dout_ready(dout_ready), .pe(o_pe[0]), .level(o_level[0]), .overflow(o_ovf[0]), .clr_ovf(clr_ovf));
  ltoh_capture_fifo #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .DEPTH(DEP), .ADD_WIDTH(AW), .EDGE_MODE(1)) u_dut1 (
    .rclk(rclk), .rst(rst), .wclk(wclk), .din(din), .dout(o_dout[1]), .dout_valid(o_valid[1]),
    .dout_ready(dout_ready), .pe(o_pe[1]), .level(o_level[1]), .overflow(o_ovf[1]), .clr_ovf(clr_ovf));
  ltoh_capture_fifo #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .DEPTH(DEP), .ADD_WIDTH(AW), .EDGE_MODE(2)) u_dut2 (
    .rclk(rclk), .rst(rst), .wclk(wclk), .din(din), .dout(o_dout[2]), .dout_valid(o_valid[2]),
    .dout_ready(dout_ready), .pe(o_pe[2]), .level(o_level[2]), .overflow(o_ovf[2]), .clr_ovf(clr_ovf));

  // reference model: hist[t] is wclk as seen at rclk edge t after reset release (hist[0] = reset value)
  int      t;
  bit      hist[$];
  int      modes[3] = '{0, 1, 2};
  bit      m_pe  [3];
  int      m_cnt [3];
  bit      m_ovf [3];
  logic [DW-1:0] m_mem [3][DEP];

  function automatic void model_reset();
    t = 0;
    hist.delete();
    hist.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      m_pe[i]  = 1'b0;
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    bit pop, push, full, a, b;
    for (int i = 0; i < 3; i++) begin
      pop  = (m_cnt[i] > 0) && dout_ready;
      push = m_pe[i];
      full = (m_cnt[i] == DEP);
      if (pop) begin
        for (int j = 0; j < DEP - 1; j++) m_mem[i][j] = m_mem[i][j+1];
        m_cnt[i]--;
      end
      if (push && m_cnt[i] < DEP) begin
        m_mem[i][m_cnt[i]] = din;
        m_cnt[i]++;
      end
      if (push && full && !pop) m_ovf[i] = 1'b1;
      else if (clr_ovf)         m_ovf[i] = 1'b0;
    end
    t++;
    hist.push_back(wclk);
    for (int i = 0; i < 3; i++) begin
      m_pe[i] = 1'b0;
      if (t >= SYNC + 1) begin
        a = hist[t-SYNC+1];
        b = hist[t-SYNC];
        case (modes[i])
          0:       m_pe[i] = a & ~b;
          1:       m_pe[i] = ~a & b;
          default: m_pe[i] = a ^ b;
        endcase
      end
    end
  endfunction

  // scoreboard
  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=0x%08h exp=0x%08h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("m%0d_pe", i),    DW'(o_pe[i]),    DW'(m_pe[i]));
      check_eq($sformatf("m%0d_valid", i), DW'(o_valid[i]), DW'(m_cnt[i] > 0));
      check_eq($sformatf("m%0d_dout", i),  o_dout[i],       (m_cnt[i] > 0) ? m_mem[i][0] : '0);
      check_eq($sformatf("m%0d_level", i), DW'(o_level[i]), DW'(m_cnt[i]));
      check_eq($sformatf("m%0d_ovf", i),   DW'(o_ovf[i]),   DW'(m_ovf[i]));
    end
  endtask

  // driver tasks: inputs change 2 time units after the active edge
  task automatic tick();
    @(posedge rclk);
    if (rst) model_edge();
    #2;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_wclk(input logic v, input logic [DW-1:0] d, input int hold);
    din  = d;
    wclk = v;
    ticks(hold);
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    ticks(6);
    dout_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; wclk = 1'b1; din = '0; dout_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    ticks(3);
    check_eq("reset_level", DW'(o_level[0]), '0);

    // 1: release with wclk high, no spurious pe
    rst = 1'b1;
    ticks(20);
    check_eq("t1_level", DW'(o_level[0]), '0);

    // 2: single rising edge
    set_wclk(1'b0, 32'h0, 6);
    drain();
    set_wclk(1'b1, 32'hA5A5_0001, 6);
    check_eq("t2_level", DW'(o_level[0]), 32'd1);
    check_eq("t2_dout",  o_dout[0], 32'hA5A5_0001);

    // 3: five edges into a 4-deep FIFO
    drain();
    for (int d = 1; d <= 5; d++) begin
      set_wclk(1'b0, din, 6);
      set_wclk(1'b1, DW'(d), 6);
    end
    check_eq("t3_level", DW'(o_level[0]), 32'd4);
    check_eq("t3_ovf",   DW'(o_ovf[0]), 32'd1);
    check_eq("t3_head",  o_dout[0], 32'd1);
    drain();
    check_eq("t3_empty_valid", DW'(o_valid[0]), '0);
    check_eq("t3_empty_dout",  o_dout[0], '0);

    // 4: push and pop while full
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("t4_clr", DW'(o_ovf[0]), '0);
    for (int d = 1; d <= 4; d++) begin
      set_wclk(1'b0, din, 6);
      set_wclk(1'b1, DW'(d), 6);
    end
    set_wclk(1'b0, din, 6);
    set_wclk(1'b1, 32'd6, 2);
    check_eq("t4_pe", DW'(o_pe[0]), 32'd1);
    dout_ready = 1'b1;
    tick();
    check_eq("t4_level", DW'(o_level[0]), 32'd4);
    check_eq("t4_ovf",   DW'(o_ovf[0]), '0);
    ticks(6);
    dout_ready = 1'b0;

    // 5: both-edge mode, repeated so pointers wrap
    for (int r = 0; r < 2; r++) begin
      drain();
      set_wclk(~wclk, 32'd7, 6);
      set_wclk(~wclk, 32'd8, 6);
      set_wclk(~wclk, 32'd9, 6);
      check_eq("t5_level", DW'(o_level[2]), 32'd3);
      check_eq("t5_head",  o_dout[2], 32'd7);
    end

    // 6: asynchronous reset mid-drain
    drain();
    for (int d = 0; d < 4; d++) begin
      set_wclk(1'b0, din, 6);
      set_wclk(1'b1, $urandom, 6);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check_eq("t6_pre_level", DW'(o_level[0]), 32'd3);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    ticks(3);
    rst = 1'b1;
    set_wclk(1'b1, din, 8);
    set_wclk(1'b0, din, 6);
    set_wclk(1'b1, 32'h600D_F00D, 6);
    check_eq("t6_level", DW'(o_level[0]), 32'd1);
    check_eq("t6_dout",  o_dout[0], 32'h600D_F00D);

    // random segments: wclk held at least SYNC+2 cycles between toggles
    for (int s = 0; s < 300; s++) begin
      din = $urandom;
      if ($urandom_range(0, 1) == 1) wclk = ~wclk;
      for (int c = 0, n = $urandom_range(4, 8); c < n; c++) begin
        dout_ready = ($urandom_range(0, 2) == 0);
        clr_ovf    = ($urandom_range(0, 7) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ltoh_capture_fifo.md
Name: ltoh_capture_fifo

Overview:
- Parametrised successor to the slow-to-fast capture stage.
- Synchronises a slow strobe clock (wclk) into the fast rclk domain through a configurable-depth synchroniser.
- Detects a selectable edge of that strobe and captures din on each detected edge into a small show-ahead FIFO.
- Presents captured words on a valid/ready interface, with occupancy, a sticky overflow flag and start-up edge suppression.
- Sits between slow producers and fast-domain consumers.

Parameters:
- DATA_WIDTH, 32: width of din and dout.
- SYNC_STAGES, 2: synchroniser flops on wclk; minimum 2.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- ADD_WIDTH, 2: log2(DEPTH); pointer width.
- EDGE_MODE, 0: capture edge; 0 = rising, 1 = falling, 2 = both.

Ports:
- rclk  input  1  sole clock; all flops rising-edge.
- rst  input  1  asynchronous, active-low reset.
- wclk  input  1  slow strobe; asynchronous to rclk; sampled only.
- din  input  DATA_WIDTH  data; stable for ≥ SYNC_STAGES+2 rclk cycles around each captured wclk edge (system constraint).
- dout  output  DATA_WIDTH  FIFO head word; 0 when empty.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer pop; a pop occurs when dout_valid && dout_ready.
- pe  output  1  one-cycle detected-edge pulse.
- level  output  ADD_WIDTH+1  FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; an edge was detected while the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - sync chain, prev flop, pointers, level, memory, overflow and arm counter all go to 0.
  - Outputs: dout=0, dout_valid=0, pe=0, level=0, overflow=0.
- Synchroniser:
  - sync[0] <= wclk; sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1]; prev <= s.
- Edge detect (combinational from flops only; glitch-free):
  - rise = s & ~prev; fall = ~s & prev.
  - pe = arm_done & (mode 0: rise; mode 1: fall; mode 2: rise | fall).
- Arming:
  - A counter counts SYNC_STAGES+1 rclk cycles after reset deassertion; arm_done goes high and then holds.
  - Edges caused by the chain filling after reset never produce pe, whatever the static wclk level.
- Capture latency:
  - wclk transition sampled at rclk edge k.
  - pe high during the cycle following edge k+SYNC_STAGES-1.
  - din is written at the end of that cycle.
  - dout_valid rises the next cycle.
- FIFO (show-ahead):
  - push = pe; pop = dout_valid & dout_ready.
  - dout = mem[rd_ptr] when level>0, else 0.
  - Pointers wrap modulo DEPTH.
  - level += push_accepted - pop.
- Boundary conditions:
  - Empty, push and no pop: word written; dout_valid next cycle; no same-cycle bypass.
  - Empty and dout_ready high: no effect.
  - Full, push and no pop: word dropped; overflow <= 1; memory, pointers and level unchanged.
  - Full, push and pop same cycle: both accepted; level stays DEPTH; no overflow.
  - Push and pop, neither full nor empty: level unchanged; both pointers advance.
  - clr_ovf and a new overflow event in the same cycle: overflow stays 1 (set wins).
- Reset mid-operation: all stored words are discarded immediately; arming restarts on release.
- EDGE_MODE 2: each wclk toggle produces exactly one pe, provided wclk half-period ≥ SYNC_STAGES+2 rclk cycles.

Test Plan:
1. Reset release with wclk held high, EDGE_MODE=0, SYNC_STAGES=2 -> pe never asserts; level stays 0 for 20 cycles.
2. Single rising wclk with din=0xA5A5_0001, dout_ready=0 -> one pe pulse 2 cycles after the sampling edge; dout_valid the next cycle; dout=0xA5A5_0001; level=1.
3. Five rising edges with din=1..5, dout_ready=0, DEPTH=4 -> level=4; overflow=1; draining yields 1,2,3,4; word 5 lost; dout=0 and dout_valid=0 after the drain.
4. FIFO full, dout_ready=1 held, sixth edge with din=6 -> pop and push in the same cycle; level stays 4; overflow not newly set; output order 1,2,3,4,6 (after clr_ovf from test 3).
5. EDGE_MODE=2, wclk toggled 3 times with din=7,8,9 -> three pe pulses; dout sequence 7,8,9; pointers wrap correctly past DEPTH on repeat.
6. rst pulsed low mid-drain with level=3 -> dout=0, dout_valid=0, level=0, overflow=0 asynchronously; the first post-arm edge captures the correct din.
